pmp_unit: RTL and testbench

- Parametrised physical memory protection unit for the CEP core, generalising the combinational PMP checker.
- Owns the pmpcfg/pmpaddr CSR storage and enforces lock and WARL write rules.
- Performs a registered one-cycle permission check behind a valid/ready request/response handshake.
- Sits between the LSU/fetch address path and the bus; the CSR file forwards PMP CSR accesses to it.

---
 rtl/pmp_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_pmp_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_unit.sv
// pmp_unit - physical memory protection unit for the CEP core.
//
// Holds the pmpcfg/pmpaddr CSR state (with lock and WARL write rules) and
// answers permission checks through a valid/ready request/response pair.
// A request is answered one cycle after it is accepted. Responses are held
// stable while the consumer stalls.
//
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   csr_we/addr/wdata     CSR write port (pmpcfg0..3 at 0x3A0, pmpaddr0..15 at 0x3B0)
//   csr_rdata             combinational read data for csr_addr (0 if not PMP)
//   req_valid/ready       check request handshake
//   req_addr/size/type    access byte address, log2 size, type (R/W/X)
//   req_priv              privilege mode (11=M, 01=S, 00=U)
//   rsp_valid/ready       response handshake
//   rsp_allow/hit/entry   verdict, match flag, winning entry index
//
// Build option: define PMP_NAPOT_EN to implement NAPOT regions. Without it,
// A=NAPOT is stored as OFF.
module pmp_unit #(
  parameter int N_ENTRIES = 16,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic [1:0]      req_type,
  input  logic [1:0]      req_priv,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_allow,
  output logic            rsp_hit,
  output logic [3:0]      rsp_entry
);

  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  logic [7:0]      cfg_q  [16];
  logic [7:0]      cfg_d  [16];
  logic [XLEN-1:0] addr_q [16];
  logic [XLEN-1:0] addr_d [16];
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_allow_q, rsp_allow_d;
  logic            rsp_hit_q,   rsp_hit_d;
  logic [3:0]      rsp_entry_q, rsp_entry_d;

  logic            is_cfg_s, is_addr_s, addr_wr_ok_s;
  logic [3:0]      a_idx_s, nxt_idx_s;
  logic [32:0]     lo_s, hi_s;
  logic [33:0]     base_s, top_s;
  logic [XLEN-1:0] prev_s;
  logic            ovl_s, cont_s, hit_s, full_s;
  logic [3:0]      idx_s;
  logic [7:0]      sel_cfg_s;
  logic            legal_s, m_mode_s, perm_s;
`ifdef PMP_NAPOT_EN
  logic [32:0]     napot_x_s, napot_mask_s;
`endif

  // Legalise a written cfg byte: reserved bits read 0, R=0/W=1 becomes R=0/W=0.
  function automatic logic [7:0] cfg_warl(input logic [7:0] w);
    logic [7:0] c;
    c = w & 8'h9F;
    if (!c[0] && c[1]) c[1] = 1'b0;
    else               c[1] = c[1];
`ifndef PMP_NAPOT_EN
    if (c[4:3] == A_NAPOT) c[4:3] = 2'b00;
    else                   c[4:3] = c[4:3];
`endif
    return c;
  endfunction

  assign is_cfg_s  = (csr_addr[11:2] == 10'h0E8);
  assign is_addr_s = (csr_addr[11:4] == 8'h3B);
  assign a_idx_s   = csr_addr[3:0];
  assign nxt_idx_s = a_idx_s + 4'd1;

  // pmpaddr i is frozen by its own lock or by a locked TOR entry above it.
  always_comb begin
    addr_wr_ok_s = (int'(a_idx_s) < N_ENTRIES) && !cfg_q[a_idx_s][7] &&
                   !((a_idx_s != 4'd15) && cfg_q[nxt_idx_s][7] &&
                     (cfg_q[nxt_idx_s][4:3] == A_TOR));
  end

  // CSR write: next-state of the cfg bytes and address registers.
  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    if (csr_we && is_cfg_s) begin
      for (int b = 0; b < 4; b++) begin
        if (((int'(csr_addr[1:0]) * 4 + b) < N_ENTRIES) &&
            !cfg_q[{csr_addr[1:0], 2'(b)}][7]) begin
          cfg_d[{csr_addr[1:0], 2'(b)}] = cfg_warl(csr_wdata[8*b +: 8]);
        end else begin
          cfg_d[{csr_addr[1:0], 2'(b)}] = cfg_q[{csr_addr[1:0], 2'(b)}];
        end
      end
    end else if (csr_we && is_addr_s && addr_wr_ok_s) begin
      addr_d[a_idx_s] = csr_wdata;
    end else begin
      addr_d[a_idx_s] = addr_q[a_idx_s];
    end
  end

  // CSR read mux.
  always_comb begin
    csr_rdata = '0;
    if (is_cfg_s) begin
      csr_rdata = {cfg_q[{csr_addr[1:0], 2'd3}], cfg_q[{csr_addr[1:0], 2'd2}],
                   cfg_q[{csr_addr[1:0], 2'd1}], cfg_q[{csr_addr[1:0], 2'd0}]};
    end else if (is_addr_s) begin
      csr_rdata = addr_q[a_idx_s];
    end else begin
      csr_rdata = '0;
    end
  end

  // Region match: every region is a half-open byte range [base, top) in 34 bits.
  // Scanning downwards leaves the lowest-index matching entry as the winner.
  always_comb begin
    lo_s   = {1'b0, req_addr};
    hi_s   = lo_s + (33'd1 << req_size) - 33'd1;
    hit_s  = 1'b0;
    full_s = 1'b0;
    idx_s  = 4'd0;
    base_s = '0;
    top_s  = '0;
    prev_s = '0;
    ovl_s  = 1'b0;
    cont_s = 1'b0;
`ifdef PMP_NAPOT_EN
    napot_x_s    = '0;
    napot_mask_s = '0;
`endif
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      prev_s = (i == 0) ? '0 : addr_q[(i == 0) ? 0 : i - 1];
      case (cfg_q[i][4:3])
        A_TOR: begin
          base_s = {2'b00, prev_s[29:0], 2'b00};
          top_s  = {2'b00, addr_q[i][29:0], 2'b00};
        end
        A_NA4: begin
          base_s = {2'b00, addr_q[i][29:0], 2'b00};
          top_s  = base_s + 34'd4;
        end
`ifdef PMP_NAPOT_EN
        A_NAPOT: begin
          // x ^ (x+1) turns the trailing ones of {addr,2'b11} into a size mask.
          napot_x_s    = {1'b0, addr_q[i][29:0], 2'b11};
          napot_mask_s = napot_x_s ^ (napot_x_s + 33'd1);
          base_s = {2'b00, addr_q[i][29:0], 2'b00} & ~{1'b0, napot_mask_s};
          top_s  = base_s + {1'b0, napot_mask_s} + 34'd1;
        end
`endif
        default: begin
          base_s = '0;
          top_s  = '0;
        end
      endcase
      ovl_s  = (base_s < top_s) && ({1'b0, lo_s} < top_s) && ({1'b0, hi_s} >= base_s);
      cont_s = ({1'b0, lo_s} >= base_s) && ({1'b0, hi_s} < top_s);
      if (ovl_s) begin
        hit_s  = 1'b1;
        idx_s  = 4'(i);
        full_s = cont_s;
      end else begin
        hit_s  = hit_s;
      end
    end
    sel_cfg_s = cfg_q[idx_s];
  end

  // Verdict and response/handshake next-state.
  always_comb begin
    legal_s  = (req_size != 2'd3) && (req_type != 2'd3);
    m_mode_s = (req_priv == 2'b11);
    case (req_type)
      2'd0:    perm_s = sel_cfg_s[0];
      2'd1:    perm_s = sel_cfg_s[1];
      2'd2:    perm_s = sel_cfg_s[2];
      default: perm_s = 1'b0;
    endcase
    rsp_valid_d = rsp_valid_q;
    rsp_allow_d = rsp_allow_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_entry_d = rsp_entry_q;
    if (req_valid && req_ready) begin
      rsp_valid_d = 1'b1;
      if (hi_s[32]) begin
        rsp_allow_d = 1'b0;
        rsp_hit_d   = 1'b0;
        rsp_entry_d = 4'd0;
      end else if (hit_s) begin
        rsp_allow_d = legal_s && full_s && (perm_s || (m_mode_s && !sel_cfg_s[7]));
        rsp_hit_d   = 1'b1;
        rsp_entry_d = idx_s;
      end else begin
        rsp_allow_d = legal_s && m_mode_s;
        rsp_hit_d   = 1'b0;
        rsp_entry_d = 4'd0;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        cfg_q[i]  <= 8'h00;
        addr_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_allow_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_entry_q <= 4'd0;
    end else begin
      cfg_q       <= cfg_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_allow_q <= rsp_allow_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_entry_q <= rsp_entry_d;
    end
  end

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_allow = rsp_allow_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_entry = rsp_entry_q;

endmodule

// File: tb/tb_pmp_unit.sv
// Self-checking bench for pmp_unit: a byte-range reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_pmp_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = 32'h0;
  logic [31:0] csr_rdata;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic [1:0]  req_type = 2'd0;
  logic [1:0]  req_priv = 2'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_allow;
  logic        rsp_hit;
  logic [3:0]  rsp_entry;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

`ifdef PMP_NAPOT_EN
  localparam logic [31:0] CFG0_A = 32'h001F1109;
  localparam logic [31:0] CFG0_L = 32'h001F1189;
  localparam logic [31:0] CFG3_W = 32'h07081C00;
`else
  localparam logic [31:0] CFG0_A = 32'h00071109;
  localparam logic [31:0] CFG0_L = 32'h00071189;
  localparam logic [31:0] CFG3_W = 32'h07080400;
`endif

  pmp_unit dut (
    .clk(clk), .rst_n(rst_n), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_type(req_type), .req_priv(req_priv), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_allow(rsp_allow), .rsp_hit(rsp_hit),
    .rsp_entry(rsp_entry)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_cfg  [16];
  logic [31:0] m_addr [16];
  logic        m_valid = 1'b0;
  logic        m_allow = 1'b0;
  logic        m_hit = 1'b0;
  logic [3:0]  m_entry = 4'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_legalise(input logic [7:0] w);
    logic [7:0] r;
    r = w;
    r[6:5] = 2'b00;
    if (r[1] && !r[0]) r[1] = 1'b0;
`ifndef PMP_NAPOT_EN
    if (r[4:3] == 2'd3) r[4:3] = 2'd0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int k;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      k = int'(a - 12'h3A0) * 4;
      return {m_cfg[k+3], m_cfg[k+2], m_cfg[k+1], m_cfg[k]};
    end
    if (a >= 12'h3B0 && a <= 12'h3BF) return m_addr[int'(a - 12'h3B0)];
    return 32'h0;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d);
    int e;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      for (int b = 0; b < 4; b++) begin
        e = int'(a - 12'h3A0) * 4 + b;
        if (!m_cfg[e][7]) m_cfg[e] = m_legalise(d[8*b +: 8]);
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      e = int'(a - 12'h3B0);
      if (!m_cfg[e][7] && !(e < 15 && m_cfg[e+1][7] && m_cfg[e+1][4:3] == 2'd1))
        m_addr[e] = d;
    end
  endtask

  task automatic m_check(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                         input logic [1:0] pv, output logic al, output logic ht, output logic [3:0] en);
    longint lo, hi, b, t, sz_b;
    int k;
    logic full, pbit, legal;
    lo = longint'(a);
    hi = lo + (longint'(1) << sz) - 1;
    al = 1'b0; ht = 1'b0; en = 4'd0; full = 1'b0;
    legal = (sz != 2'd3) && (ty != 2'd3);
    if (hi > 64'h0_FFFF_FFFF) return;
    for (int i = 0; i < 16; i++) begin
      b = 0; t = 0;
      case (m_cfg[i][4:3])
        2'd1: begin
          if (i > 0) b = longint'(m_addr[i-1] & 32'h3FFF_FFFF) * 4;
          t = longint'(m_addr[i] & 32'h3FFF_FFFF) * 4;
        end
        2'd2: begin
          b = longint'(m_addr[i] & 32'h3FFF_FFFF) * 4;
          t = b + 4;
        end
        2'd3: begin
`ifdef PMP_NAPOT_EN
          k = 0;
          while (k < 30 && m_addr[i][k]) k++;
          sz_b = longint'(1) << (k + 3);
          b = (longint'(m_addr[i] & 32'h3FFF_FFFF) * 4) / sz_b * sz_b;
          t = b + sz_b;
`endif
        end
        default: ;
      endcase
      if (b < t && lo < t && hi >= b) begin
        ht = 1'b1;
        en = 4'(i);
        full = (lo >= b) && (hi < t);
        break;
      end
    end
    if (ht) begin
      pbit = (ty == 2'd3) ? 1'b0 : m_cfg[en][ty];
      al = legal && full && (pbit || (pv == 2'b11 && !m_cfg[en][7]));
    end else begin
      al = legal && (pv == 2'b11);
    end
  endtask

  // Model update at each active edge (inputs are stable there).
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_cfg[i] = 8'h00;
        m_addr[i] = 32'h0;
      end
      m_valid = 1'b0; m_allow = 1'b0; m_hit = 1'b0; m_entry = 4'd0;
    end else begin
      if (req_valid && (!m_valid || rsp_ready)) begin
        m_check(req_addr, req_size, req_type, req_priv, m_allow, m_hit, m_entry);
        m_valid = 1'b1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      if (csr_we) m_write(csr_addr, csr_wdata);
    end
  end

  // Per-cycle comparison on the inactive edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rsp_allow", 32'(rsp_allow), 32'(m_allow));
        chk("rsp_hit", 32'(rsp_hit), 32'(m_hit));
        chk("rsp_entry", 32'(rsp_entry), 32'(m_entry));
      end
      chk("csr_rdata", csr_rdata, m_read(csr_addr));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0; csr_addr = 12'h000;
  endtask

  task automatic csr_rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(nm, csr_rdata, exp);
    csr_addr = 12'h000;
  endtask

  task automatic do_req(input string nm, input logic [31:0] a, input logic [1:0] sz,
                        input logic [1:0] ty, input logic [1:0] pv,
                        input logic ea, input logic eh, input logic [3:0] ee);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_type = ty; req_priv = pv;
    tick();
    req_valid = 1'b0;
    chk({nm, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, ".allow"}, 32'(rsp_allow), 32'(ea));
    chk({nm, ".hit"}, 32'(rsp_hit), 32'(eh));
    chk({nm, ".entry"}, 32'(rsp_entry), 32'(ee));
  endtask

  logic [31:0] hs_addr [4] = '{32'h2000, 32'h0, 32'h1800, 32'h3000};
  logic [1:0]  hs_size [4] = '{2'd2, 2'd0, 2'd2, 2'd2};
  logic [1:0]  hs_priv [4] = '{2'd0, 2'd0, 2'd0, 2'd3};
  logic        hs_allow[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic        hs_hit  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0]  hs_entry[4] = '{4'd1, 4'd0, 4'd0, 4'd0};
  logic [31:0] wd;
  logic [7:0]  bv;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // reset state
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_allow", 32'(rsp_allow), 32'd0);
    chk("rst.rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst.rsp_entry", 32'(rsp_entry), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    csr_rd("rst.pmpcfg0", 12'h3A0, 32'h0);
    csr_rd("rst.pmpaddr5", 12'h3B5, 32'h0);
    do_req("rst.u_rd", 32'h1000, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0);
    do_req("rst.m_rd", 32'h1000, 2'd2, 2'd0, 2'd3, 1'b1, 1'b0, 4'd0);

    // TOR entry 0 covering [0, 0x1000) with R+W
    csr_wr(12'h3B0, 32'h400);
    csr_wr(12'h3A0, 32'h0000000B);
    csr_rd("tor.cfg0", 12'h3A0, 32'h0000000B);
    do_req("tor.u_wr", 32'hFFC, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1, 4'd0);
    do_req("tor.u_x", 32'h800, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 4'd0);
    do_req("tor.u_miss", 32'h1000, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0);

    // NA4 entry 1 at 0x2000, partial overlap
    csr_wr(12'h3B1, 32'h800);
    csr_wr(12'h3A0, 32'h0000110B);
    do_req("na4.partial", 32'h1FFE, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'd1);

    // overlapping NAPOT entry 2, entry 0 now R only
    csr_wr(12'h3B2, 32'h1FF);
    csr_wr(12'h3A0, 32'h001F1109);
    csr_rd("napot.cfg0", 12'h3A0, CFG0_A);
    do_req("ovl.u_wr", 32'h100, 2'd2, 2'd1, 2'd0, 1'b0, 1'b1, 4'd0);

    // lock entry 0
    csr_wr(12'h3A0, 32'h001F1189);
    csr_rd("lock.cfg0", 12'h3A0, CFG0_L);
    csr_wr(12'h3B0, 32'h0);
    csr_rd("lock.addr0", 12'h3B0, 32'h400);
    csr_wr(12'h3A0, 32'h001F1100);
    csr_rd("lock.cfg0_keep", 12'h3A0, CFG0_L);
    do_req("lock.m_wr", 32'h100, 2'd2, 2'd1, 2'd3, 1'b0, 1'b1, 4'd0);
    do_req("lock.m_rd", 32'h100, 2'd2, 2'd0, 2'd3, 1'b1, 1'b1, 4'd0);

    // locked TOR entry 5 freezes pmpaddr4 as well as pmpaddr5
    csr_wr(12'h3A1, 32'h00008900);
    csr_rd("tor_lock.cfg1", 12'h3A1, 32'h00008900);
    csr_wr(12'h3B4, 32'h1234);
    csr_rd("tor_lock.addr4", 12'h3B4, 32'h0);
    csr_wr(12'h3B5, 32'h99);
    csr_rd("tor_lock.addr5", 12'h3B5, 32'h0);
    csr_wr(12'h3B6, 32'h55);
    csr_rd("tor_lock.addr6", 12'h3B6, 32'h55);

    // WARL legalisation
    csr_wr(12'h3A3, 32'h070A1E62);
    csr_rd("warl.cfg3", 12'h3A3, CFG3_W);
    csr_rd("nonpmp", 12'h300, 32'h0);

    // wrap, illegal size, illegal type
    do_req("wrap", 32'hFFFF_FFFE, 2'd2, 2'd0, 2'd3, 1'b0, 1'b0, 4'd0);
    do_req("bad_size", 32'h1000, 2'd3, 2'd0, 2'd3, 1'b0, 1'b0, 4'd0);
    do_req("bad_type_m", 32'h3000, 2'd0, 2'd3, 2'd3, 1'b0, 1'b0, 4'd0);
    do_req("bad_type_hit", 32'h0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b1, 4'd0);

    // handshake: stall with a pending request, then back-to-back
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'hFFC; req_size = 2'd2; req_type = 2'd0; req_priv = 2'd0;
    tick();
    req_addr = hs_addr[0]; req_size = hs_size[0]; req_priv = hs_priv[0];
    for (int c = 0; c < 3; c++) begin
      chk("stall.req_ready", 32'(req_ready), 32'd0);
      chk("stall.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall.rsp_allow", 32'(rsp_allow), 32'd1);
      chk("stall.rsp_hit", 32'(rsp_hit), 32'd1);
      chk("stall.rsp_entry", 32'(rsp_entry), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b2b.valid", 32'(rsp_valid), 32'd1);
      chk("b2b.allow", 32'(rsp_allow), 32'(hs_allow[k]));
      chk("b2b.hit", 32'(rsp_hit), 32'(hs_hit[k]));
      chk("b2b.entry", 32'(rsp_entry), 32'(hs_entry[k]));
      if (k < 3) begin
        req_addr = hs_addr[k+1]; req_size = hs_size[k+1]; req_priv = hs_priv[k+1];
      end
    end
    rst_n = 1'b0;
    tick();
    chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    tick();
    chk("midrst.after", 32'(rsp_valid), 32'd0);

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      rst_n = (n % 700 == 699) ? 1'b0 : 1'b1;
      csr_we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1: begin
          csr_addr = 12'h3A0 + 12'($urandom_range(0, 3));
          for (int b = 0; b < 4; b++) begin
            bv = 8'($urandom) & 8'h7F;
            if ($urandom_range(0, 15) == 0) bv[7] = 1'b1;
            wd[8*b +: 8] = bv;
          end
          csr_wdata = wd;
        end
        9: begin
          csr_addr = 12'($urandom);
          csr_wdata = $urandom;
        end
        default: begin
          csr_addr = 12'h3B0 + 12'($urandom_range(0, 15));
          csr_wdata = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h7FF));
        end
      endcase
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0, 1:    req_addr = $urandom;
        2:       req_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: req_addr = 32'($urandom_range(0, 32'h2100));
      endcase
      req_size = 2'($urandom_range(0, 3));
      req_type = 2'($urandom_range(0, 3));
      req_priv = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst_n = 1'b1;
    csr_we = 1'b0;
    req_valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
